// File: rtl/seq_to_para_if.sv
// rtl/seq_to_para_if.sv - word-in / operand-out bundle for the RSA serial-to-parallel collector
interface seq_to_para_if #(
    parameter int RSA_LEN = 512,
    parameter int BUS_W   = 32,
    parameter int CNT_W   = 5
);
    logic               clr;
    logic               wr;
    logic [BUS_W-1:0]   data_in;
    logic [RSA_LEN-1:0] data_out;
    logic               valid;
    logic               done;
    logic               busy;
    logic [CNT_W-1:0]   wcnt;

    modport master (
        output clr, wr, data_in,
        input  data_out, valid, done, busy, wcnt
    );

    modport slave (
        input  clr, wr, data_in,
        output data_out, valid, done, busy, wcnt
    );
endinterface

// File: rtl/seq_to_para.sv
// rtl/seq_to_para.sv - collects BUS_W-bit words, LS word first, into one RSA_LEN-bit operand
module seq_to_para #(
    parameter int RSA_LEN = 512,
    parameter int BUS_W   = 32,
    parameter int CNT_W   = 5
) (
    input  logic        clk,
    input  logic        rst,
    seq_to_para_if.slave bus
);
    localparam int NW = RSA_LEN / BUS_W;

    typedef enum logic [1:0] {IDLE, FILL, FULL} state_t;

    state_t             state_q, state_d;
    logic [RSA_LEN-1:0] data_q, data_d;
    logic [CNT_W-1:0]   wcnt_q, wcnt_d, wcnt_inc;
    logic               valid_q, valid_d;
    logic               done_q, done_d;
    logic               busy_q, busy_d;

    always_comb begin
        state_d  = state_q;
        data_d   = data_q;
        wcnt_d   = wcnt_q;
        valid_d  = valid_q;
        done_d   = 1'b0;
        // A word taken outside FILL always opens a fresh frame, so FULL never overflows.
        wcnt_inc = (state_q == FILL) ? wcnt_q + 1'b1 : CNT_W'(1);
        if (bus.clr) begin
            state_d = IDLE;
            wcnt_d  = '0;
            valid_d = 1'b0;
        end else if (bus.wr) begin
            data_d = {bus.data_in, data_q[RSA_LEN-1:BUS_W]};
            wcnt_d = wcnt_inc;
            if (wcnt_inc == CNT_W'(NW)) begin
                state_d = FULL;
                valid_d = 1'b1;
                done_d  = 1'b1;
            end else begin
                state_d = FILL;
                valid_d = 1'b0;
            end
        end
        busy_d = (state_d == FILL);
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= IDLE;
            data_q  <= '0;
            wcnt_q  <= '0;
            valid_q <= 1'b0;
            done_q  <= 1'b0;
            busy_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            data_q  <= data_d;
            wcnt_q  <= wcnt_d;
            valid_q <= valid_d;
            done_q  <= done_d;
            busy_q  <= busy_d;
        end
    end

    assign bus.data_out = data_q;
    assign bus.wcnt     = wcnt_q;
    assign bus.valid    = valid_q;
    assign bus.done     = done_q;
    assign bus.busy     = busy_q;
endmodule

// File: doc/seq_to_para.md
Name: seq_to_para

Overview:
- Serial-to-parallel word collector for the RSA datapath.
- Accepts a stream of BUS_W-bit words from the host bus and assembles them into one RSA_LEN-bit operand (modulus, exponent or message) for the modular-exponentiation core.
- Word order is least-significant word first: the first accepted word lands in data_out[BUS_W-1:0], and the last lands in the top word.
- Sits between the host interface register file and the core's operand inputs.

Parameters:
- RSA_LEN, 512, operand width in bits; must be an integer multiple of BUS_W.
- BUS_W, 32, bus word width in bits.
- CNT_W, 5, word-counter width; must satisfy 2^CNT_W > RSA_LEN/BUS_W.

Ports:
- clk  in  1  clock; all state updates on rising edge.
- rst  in  1  reset, synchronous, active-high.
- clr  in  1  synchronous abort: drop the partial frame and return to IDLE.
- wr  in  1  data_in holds a valid word this cycle.
- data_in  in  BUS_W  incoming word.
- data_out  out  RSA_LEN  assembled operand (the shift register, driven directly).
- valid  out  1  data_out holds a complete frame; level signal.
- done  out  1  one-cycle pulse in the cycle after the final word is accepted.
- busy  out  1  frame partially received (FILL state).
- wcnt  out  CNT_W  number of words accepted in the current frame.

Behaviour:
- NW = RSA_LEN/BUS_W (16 at defaults).
- Reset (rst=1 at an edge) overrides everything, including mid-frame:
  - data_out=0, wcnt=0, valid=0, done=0, busy=0, state=IDLE.
- Accepting a word (wr=1 and clr=0): data_out <= {data_in, data_out[RSA_LEN-1:BUS_W]}. After NW accepts, word 0 sits at [BUS_W-1:0].
- States:
  - IDLE (wcnt=0, busy=0): wr -> wcnt=1, state FILL, valid<=0.
  - FILL (1<=wcnt<=NW-1, busy=1):
    - wr with wcnt<NW-1 -> wcnt+1.
    - wr with wcnt=NW-1 -> wcnt<=NW, state FULL, valid<=1, done<=1 for exactly one cycle.
    - no wr -> hold all state; gaps of any length are allowed.
  - FULL (wcnt=NW, valid=1, busy=0):
    - data_out is stable until the next accepted word.
    - wr -> starts a new frame: shift applies, wcnt=1, valid<=0, state FILL. Back-to-back frames need no idle cycle.
- Latency: the final word is sampled at edge k; data_out, valid and done are visible after edge k. done deasserts after edge k+1 unless that edge completes another frame (impossible for NW>1).
- clr=1 (not in reset): wcnt=0, valid=0, busy=0, done=0, state IDLE. data_out is NOT cleared.
  - clr with wr in the same cycle: clr wins and the word is dropped (no shift).
- wr while in FULL never overflows; it always begins a new frame.
- data_out during FILL is a partial value; consumers must qualify it with valid.
- No X propagation: wr is sampled only as 1/0, and data_in is don't-care when wr=0.

Test Plan:
- Full frame: after rst, send 16 words 0x00000001..0x00000010 on consecutive cycles.
  - Required: data_out[31:0]=0x00000001, data_out[511:480]=0x00000010, valid=1, wcnt=16.
  - done is high for exactly one cycle, immediately after the 16th word's edge.
- Gapped input: the same 16 words with random 0-5 cycle wr gaps.
  - Required: identical data_out; busy=1 throughout the frame; single done pulse.
- Back-to-back frames: frame A (all words 0xAAAAAAAA) followed without a gap by frame B (word i = 0xB0000000+i).
  - Required: valid drops on B's first word.
  - After B: data_out[31:0]=0xB0000000, data_out[511:480]=0xB000000F; two done pulses total.
- Abort: 7 words, then clr=1 asserted together with wr (data 0xDEADBEEF), then 16 words 0x100..0x10F.
  - Required: 0xDEADBEEF is absent; wcnt=0 after clr; final data_out[31:0]=0x100, data_out[511:480]=0x10F.
- Reset mid-frame: 9 words, then rst for 1 cycle.
  - Required: data_out=0, wcnt=0, valid=0, busy=0, done=0.
  - A subsequent 16-word frame assembles correctly.
- Idle robustness: wr=0 with random data_in for 100 cycles after a completed frame.
  - Required: data_out, valid=1 and wcnt=16 unchanged; done stays 0.
